// File: rtl/aes_round_engine.sv
// rtl/aes_round_engine.sv - iterative AES encryption round engine
//
// Purpose: accepts one 128-bit block plus a fully expanded key schedule, applies the initial
//   AddRoundKey, then runs NR rounds, UNROLL rounds per clock. The final round skips MixColumns.
//   The ciphertext is held on a valid/ready output port until it is taken.
// Optional feature: AES_ZEROIZE_EN clears the state and key registers on the output handshake,
//   so out reads 0 while idle. Without it, the last ciphertext and key stay in the registers.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   block + key presented          in_ready   high only while idle
//   key        expanded key, rk0 in the MSBs   state_in   plaintext, s0,0 in [127:120], column-major
//   out_valid  ciphertext available            out_ready  downstream accepts ciphertext
//   out        ciphertext (state byte order)   busy       high while running or holding a result
module aes_round_engine #(
  parameter int NR     = 10,
  parameter int UNROLL = 1,
  parameter int KEY_W  = 128*(NR+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] key,
  input  logic [127:0]     state_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out,
  output logic             busy
);

  localparam int RW         = $clog2(NR+2);
  localparam int LAST_START = NR - UNROLL + 1;   // rnd value of the cycle that computes round NR

  generate
    if (UNROLL < 1 || (NR % UNROLL) != 0) begin : g_bad_unroll
      $error("aes_round_engine: UNROLL must divide NR");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t             fsm;
  logic [RW-1:0]    rnd;
  logic [127:0]     state_reg;
  logic [KEY_W-1:0] key_reg;
  logic [127:0]     stage [UNROLL+1];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as the field inverse (a^254, which maps 0 to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] base;
    inv  = 8'h01;
    base = a;
    for (int i = 1; i < 8; i++) begin
      base = gf_mul(base, base);
      inv  = gf_mul(inv, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Beyond round NR there is no key; those indices only occur while no round is being used.
  function automatic logic [127:0] round_key(input logic [KEY_W-1:0] k, input int r);
    if (r > NR) return '0;
    return k[KEY_W-1-128*r -: 128];
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) b[k] = sbox(s[127-8*k -: 8]);
    // Byte k sits at row k%4, column k/4; row i rotates left by i columns.
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++)
        t[4*c+i] = b[4*((c+i)%4)+i];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = t[k] ^ rk[127-8*k -: 8];
    return r;
  endfunction

  // UNROLL chained rounds starting at round rnd.
  always_comb begin
    stage[0] = state_reg;
    for (int u = 0; u < UNROLL; u++) begin
      stage[u+1] = aes_round(stage[u], round_key(key_reg, int'(rnd) + u),
                             (int'(rnd) + u) == NR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rnd       <= '0;
      state_reg <= '0;
      key_reg   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_reg <= state_in ^ key[KEY_W-1 -: 128];
            key_reg   <= key;
            rnd       <= RW'(1);
            fsm       <= RUN;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          state_reg <= stage[UNROLL];
          rnd       <= rnd + RW'(UNROLL);
          if (int'(rnd) == LAST_START) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            rnd       <= '0;
`ifdef AES_ZEROIZE_EN
            state_reg <= '0;
            key_reg   <= '0;
`endif
          end
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          rnd       <= '0;
        end
      endcase
    end
  end

  // Intermediate round states are never exposed on the output.
  assign out = (fsm == RUN) ? '0 : state_reg;

endmodule
